// File: rtl/muntjac_icache_uncached.sv
// muntjac_icache_uncached: single-line-buffer instruction fetch unit with redirect handling
package muntjac_icache_pkg;
  typedef enum logic [2:0] {
    IF_PREFETCH,
    IF_MISPREDICT,
    IF_PROT_CHANGED,
    IF_SATP_CHANGED,
    IF_FENCE_I
  } if_reason_e;
endpackage

interface icache_intf #(parameter int XLEN = 64);
  import muntjac_icache_pkg::*;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  if_reason_e      req_reason;
  logic            req_prv;
  logic            req_sum;
  logic [XLEN-1:0] req_atp;
  logic            resp_valid;
  logic [31:0]     resp_instr;
  logic            resp_exception;
  logic            resp_exception_plus2;
  modport provider (
    input  req_valid, req_pc, req_reason, req_prv, req_sum, req_atp,
    output resp_valid, resp_instr, resp_exception, resp_exception_plus2
  );
  modport user (
    output req_valid, req_pc, req_reason, req_prv, req_sum, req_atp,
    input  resp_valid, resp_instr, resp_exception, resp_exception_plus2
  );
endinterface

module muntjac_icache_uncached
  import muntjac_icache_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PhysAddrLen = 56
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  icache_intf.provider           cache,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PhysAddrLen-4:0] mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [63:0]            mem_resp_data,
  input  logic                   mem_resp_error
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                 state;
  logic                   buf_valid;
  logic [PhysAddrLen-4:0] buf_tag;
  logic [63:0]            buf_data;
  logic                   sel_q;
  logic                   pend_valid;
  logic [XLEN-1:0]        pend_pc;
  if_reason_e             pend_reason;
  logic                   stale;
  logic                   resp_valid;
  logic [31:0]            resp_instr;
  logic                   resp_exception;

  // A request being evaluated is the incoming one if present, else the pending slot;
  // evaluation happens in IDLE or as soon as a superseded read has drained.
  logic [XLEN-1:0]        src_pc;
  if_reason_e             src_reason;
  logic [PhysAddrLen-4:0] src_tag;
  logic                   fence, hit, eval, capture;

  assign src_pc     = cache.req_valid ? cache.req_pc : pend_pc;
  assign src_reason = cache.req_valid ? cache.req_reason : pend_reason;
  assign src_tag    = src_pc[PhysAddrLen-1:3];
  assign fence      = src_reason == IF_FENCE_I;
  assign hit        = buf_valid && buf_tag == src_tag && !fence;
  assign eval       = (cache.req_valid || pend_valid) &&
                      (state == IDLE || (state == WAIT && mem_resp_valid && (stale || cache.req_valid)));
  assign capture    = cache.req_valid && state != IDLE && !eval;

  assign cache.resp_valid           = resp_valid;
  assign cache.resp_instr           = resp_instr;
  assign cache.resp_exception       = resp_exception;
  assign cache.resp_exception_plus2 = 1'b0;

  logic unused;
  assign unused = ^{cache.req_prv, cache.req_sum, cache.req_atp, src_pc};

  // Fetch FSM with line buffer, pending redirect slot and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      buf_valid      <= 1'b0;
      buf_tag        <= '0;
      buf_data       <= '0;
      sel_q          <= 1'b0;
      pend_valid     <= 1'b0;
      pend_pc        <= '0;
      pend_reason    <= IF_PREFETCH;
      stale          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_instr     <= '0;
      resp_exception <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (capture) begin
        pend_valid  <= 1'b1;
        pend_pc     <= cache.req_pc;
        pend_reason <= cache.req_reason;
        stale       <= state != RESP;
      end
      if (eval) begin
        pend_valid <= 1'b0;
        stale      <= 1'b0;
        if (fence) buf_valid <= 1'b0;
        if (hit) begin
          resp_valid     <= 1'b1;
          resp_instr     <= src_pc[2] ? buf_data[63:32] : buf_data[31:0];
          resp_exception <= 1'b0;
          state          <= IDLE;
        end else begin
          sel_q         <= src_pc[2];
          mem_req_valid <= 1'b1;
          mem_req_addr  <= src_tag;
          state         <= REQ;
        end
      end else begin
        case (state)
          REQ: if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
          WAIT: if (mem_resp_valid && !cache.req_valid) begin
            resp_valid     <= 1'b1;
            resp_instr     <= sel_q ? mem_resp_data[63:32] : mem_resp_data[31:0];
            resp_exception <= mem_resp_error;
            buf_valid      <= !mem_resp_error;
            buf_tag        <= mem_req_addr;
            buf_data       <= mem_resp_data;
            state          <= RESP;
          end
          RESP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
